// File: rtl/mvu_pkg.sv
// Shared widths and sequencer state type for the MVU job sequencer.
//   BWBANKA - weight bank address width
//   BDBANKA - data bank address width
//   BCNTDWN - job read-count width
//   BSTRIDE - AGU stride width (two's complement)
//   BLENGTH - AGU loop-length width (count minus one)
//   BPREC   - operand precision field width used elsewhere in the MVU
package mvu_pkg;

  localparam int unsigned BWBANKA = 9;
  localparam int unsigned BDBANKA = 15;
  localparam int unsigned BCNTDWN = 29;
  localparam int unsigned BSTRIDE = 15;
  localparam int unsigned BLENGTH = 15;
  localparam int unsigned BPREC   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin,
    StDone
  } seq_state_e;

endpackage

// File: rtl/mvu_agu.sv
// Three-level nested-loop address generator.
//   clk, rst             - clock, synchronous active-high reset
//   load                 - latch base/strides/lengths, clear loop counters
//   step                 - advance one position in the pattern
//   base                 - start address
//   stride_0/1/2         - per-level address increments (two's complement)
//   length_0/1/2         - per-level loop counts minus one
//   addr                 - current address
module mvu_agu
  import mvu_pkg::*;
#(
  parameter int unsigned AddrW = BDBANKA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [AddrW-1:0]   base,
  input  logic [BSTRIDE-1:0] stride_0,
  input  logic [BSTRIDE-1:0] stride_1,
  input  logic [BSTRIDE-1:0] stride_2,
  input  logic [BLENGTH-1:0] length_0,
  input  logic [BLENGTH-1:0] length_1,
  input  logic [BLENGTH-1:0] length_2,
  output logic [AddrW-1:0]   addr
);

  logic [BSTRIDE-1:0] stride_0_q, stride_1_q, stride_2_q;
  logic [BLENGTH-1:0] length_0_q, length_1_q, length_2_q;
  logic [BLENGTH-1:0] cnt_0_q, cnt_1_q, cnt_2_q;
  logic [AddrW-1:0]   addr_q;

  // Fit a stride to the address width; modulo arithmetic makes truncation
  // equivalent to a signed add.
  function automatic logic [AddrW-1:0] fit(input logic [BSTRIDE-1:0] s);
    return AddrW'($signed(s));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stride_0_q <= '0;
      stride_1_q <= '0;
      stride_2_q <= '0;
      length_0_q <= '0;
      length_1_q <= '0;
      length_2_q <= '0;
      cnt_0_q    <= '0;
      cnt_1_q    <= '0;
      cnt_2_q    <= '0;
      addr_q     <= '0;
    end else if (load) begin
      stride_0_q <= stride_0;
      stride_1_q <= stride_1;
      stride_2_q <= stride_2;
      length_0_q <= length_0;
      length_1_q <= length_1;
      length_2_q <= length_2;
      cnt_0_q    <= '0;
      cnt_1_q    <= '0;
      cnt_2_q    <= '0;
      addr_q     <= base;
    end else if (step) begin
      if (cnt_0_q < length_0_q) begin
        cnt_0_q <= cnt_0_q + 1'b1;
        addr_q  <= addr_q + fit(stride_0_q);
      end else if (cnt_1_q < length_1_q) begin
        cnt_0_q <= '0;
        cnt_1_q <= cnt_1_q + 1'b1;
        addr_q  <= addr_q + fit(stride_1_q);
      end else if (cnt_2_q < length_2_q) begin
        cnt_0_q <= '0;
        cnt_1_q <= '0;
        cnt_2_q <= cnt_2_q + 1'b1;
        addr_q  <= addr_q + fit(stride_2_q);
      end else begin
        // Pattern complete: restart the loops from the moved base.
        cnt_0_q <= '0;
        cnt_1_q <= '0;
        cnt_2_q <= '0;
        addr_q  <= addr_q + fit(stride_2_q);
      end
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/mvu_seq.sv
// Per-MVU job sequencer: latches a job on start, issues countdown granted
// data reads with matching weight addresses, then pulses quant_start and done.
//   clk, rst                 - clock, synchronous active-high reset
//   start / busy / done      - job handshake
//   countdown                - number of granted reads in the job
//   wbaseaddr, wstride_*, wlength_* - weight address pattern
//   ibaseaddr, istride_*, ilength_* - input data address pattern
//   rdw_addr                 - weight read address (no handshake)
//   rdd_en / rdd_grnt / rdd_addr - data read request, grant, address
//   acc_clr                  - accumulator clear on the first granted read
//   quant_start              - one-cycle quantizer start
module mvu_seq
  import mvu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic [BCNTDWN-1:0] countdown,
  input  logic [BWBANKA-1:0] wbaseaddr,
  input  logic [BDBANKA-1:0] ibaseaddr,
  input  logic [BSTRIDE-1:0] wstride_0,
  input  logic [BSTRIDE-1:0] wstride_1,
  input  logic [BSTRIDE-1:0] wstride_2,
  input  logic [BLENGTH-1:0] wlength_0,
  input  logic [BLENGTH-1:0] wlength_1,
  input  logic [BLENGTH-1:0] wlength_2,
  input  logic [BSTRIDE-1:0] istride_0,
  input  logic [BSTRIDE-1:0] istride_1,
  input  logic [BSTRIDE-1:0] istride_2,
  input  logic [BLENGTH-1:0] ilength_0,
  input  logic [BLENGTH-1:0] ilength_1,
  input  logic [BLENGTH-1:0] ilength_2,
  output logic [BWBANKA-1:0] rdw_addr,
  output logic               rdd_en,
  input  logic               rdd_grnt,
  output logic [BDBANKA-1:0] rdd_addr,
  output logic               acc_clr,
  output logic               quant_start
);

  seq_state_e         state_q;
  logic [BCNTDWN-1:0] cnt_q;
  logic               first_q;
  logic               load;
  logic               step;

  assign load = (state_q == StIdle) && start;
  assign step = (state_q == StRun) && rdd_grnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q   <= countdown;
            first_q <= 1'b1;
            state_q <= (countdown != '0) ? StRun : StFin;
          end
        end
        StRun: begin
          if (rdd_grnt) begin
            first_q <= 1'b0;
            cnt_q   <= cnt_q - 1'b1;
            if (cnt_q == BCNTDWN'(1)) state_q <= StFin;
          end
        end
        StFin:   state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != StIdle);
    rdd_en      = (state_q == StRun);
    quant_start = (state_q == StFin);
    done        = (state_q == StDone);
    // Only combinational output: must coincide with the granting cycle.
    acc_clr     = rdd_en && rdd_grnt && first_q;
  end

  mvu_agu #(
    .AddrW(BWBANKA)
  ) u_wagu (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .base     (wbaseaddr),
    .stride_0 (wstride_0),
    .stride_1 (wstride_1),
    .stride_2 (wstride_2),
    .length_0 (wlength_0),
    .length_1 (wlength_1),
    .length_2 (wlength_2),
    .addr     (rdw_addr)
  );

  mvu_agu #(
    .AddrW(BDBANKA)
  ) u_iagu (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .base     (ibaseaddr),
    .stride_0 (istride_0),
    .stride_1 (istride_1),
    .stride_2 (istride_2),
    .length_0 (ilength_0),
    .length_1 (ilength_1),
    .length_2 (ilength_2),
    .addr     (rdd_addr)
  );

endmodule
